// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler.
package hdmi_pkg;

    // TMDS period code presented to the three channel encoders.
    typedef enum logic [2:0] {
        CTRL        = 3'd0,
        VID_PRE     = 3'd1,
        VID_GB      = 3'd2,
        VIDEO       = 3'd3,
        DI_PRE      = 3'd4,
        DI_GB_LEAD  = 3'd5,
        DI_DATA     = 3'd6,
        DI_GB_TRAIL = 3'd7
    } period_t;

    // Data-island sequencer states.
    typedef enum logic [2:0] {
        ISL_IDLE     = 3'd0,
        ISL_ARMED    = 3'd1,
        ISL_PRE      = 3'd2,
        ISL_GB_LEAD  = 3'd3,
        ISL_DATA     = 3'd4,
        ISL_GB_TRAIL = 3'd5
    } island_state_t;

    localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
    localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

    localparam int PRE_LEN  = 8;
    localparam int GB_LEN   = 2;
    localparam int PKT_LEN  = 32;
    localparam int MIN_CTRL = 12;

endpackage

// File: rtl/hdmi_island_fsm.sv
// Data-island sequencer: owns the requester handshake, the island phases,
// the phase sub-counter and the completion pulse. It exposes the phase of
// the column currently presented so the top can register it together with
// the video decode.
module hdmi_island_fsm
    import hdmi_pkg::*;
#(
    parameter int ISLAND_START = 656
) (
    input  logic          pix_clk,
    input  logic          reset,
    input  logic [15:0]   column,
    input  logic          pkt_valid,
    input  logic          override,
    output logic          pkt_ready,
    output logic          pkt_done,
    output island_state_t phase_state,
    output logic [4:0]    pkt_word
);

    island_state_t r_state;
    logic [5:0]    r_cnt;
    logic          r_pkt_done;

    island_state_t w_next_state;
    logic [5:0]    w_next_cnt;
    logic          w_next_done;
    logic          w_ready;

    // Packets are only taken one column before the island, and only when idle,
    // so at most one island can start per line.
    assign w_ready   = !reset && (r_state == ISL_IDLE) && (column == 16'(ISLAND_START - 1));
    assign pkt_ready = w_ready;

    // Phase of the current column, derived from the phase of the previous one.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 6'd1;
        case (r_state)
            ISL_IDLE: begin
                w_next_cnt = 6'd0;
                if (pkt_valid && w_ready) begin
                    w_next_state = ISL_ARMED;
                end
            end
            ISL_ARMED: begin
                w_next_state = ISL_PRE;
                w_next_cnt   = 6'd0;
            end
            ISL_PRE: begin
                if (r_cnt == 6'(PRE_LEN - 1)) begin
                    w_next_state = ISL_GB_LEAD;
                    w_next_cnt   = 6'd0;
                end
            end
            ISL_GB_LEAD: begin
                if (r_cnt == 6'(GB_LEN - 1)) begin
                    w_next_state = ISL_DATA;
                    w_next_cnt   = 6'd0;
                end
            end
            ISL_DATA: begin
                if (r_cnt == 6'(PKT_LEN - 1)) begin
                    w_next_state = ISL_GB_TRAIL;
                    w_next_cnt   = 6'd0;
                end
            end
            ISL_GB_TRAIL: begin
                if (r_cnt == 6'(GB_LEN - 1)) begin
                    w_next_state = ISL_IDLE;
                    w_next_cnt   = 6'd0;
                end
            end
            default: begin
                w_next_state = ISL_IDLE;
                w_next_cnt   = 6'd0;
            end
        endcase

        // A video period (or an out-of-frame position) on top of an island
        // kills it outright; the packet is dropped without completion.
        if (override && (w_next_state != ISL_IDLE)) begin
            w_next_state = ISL_IDLE;
            w_next_cnt   = 6'd0;
        end

        // Completion coincides with the last trailing guard-band column.
        w_next_done = (w_next_state == ISL_GB_TRAIL) && (w_next_cnt == 6'(GB_LEN - 1));
    end

    // Island state, sub-counter and completion pulse registers.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            r_state    <= ISL_IDLE;
            r_cnt      <= 6'd0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_pkt_done <= w_next_done;
        end
    end

    assign phase_state = w_next_state;
    assign pkt_word    = w_next_cnt[4:0];
    assign pkt_done    = r_pkt_done;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period scheduler: decodes row/column into a registered
// period code, preamble CTL bits and packet word index, giving video
// periods priority over the data-island sequencer.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int HACTIVE      = 640,
    parameter int HTOTAL       = 800,
    parameter int VACTIVE      = 480,
    parameter int VTOTAL       = 525,
    parameter int ISLAND_START = 656
) (
    input  logic        pix_clk,
    input  logic        reset,
    input  logic [15:0] column,
    input  logic [15:0] row,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    output logic        pkt_done,
    output period_t     period,
    output logic [3:0]  ctl,
    output logic [4:0]  pkt_index
);

    logic          w_in_range;
    logic [15:0]   w_next_row;
    logic          w_next_active;
    logic          w_video;
    logic          w_vid_pre;
    logic          w_vid_gb;
    logic          w_override;
    island_state_t w_isl_state;
    logic [4:0]    w_isl_word;

    period_t       w_period;
    logic [3:0]    w_ctl;
    logic [4:0]    w_idx;

    period_t       r_period;
    logic [3:0]    r_ctl;
    logic [4:0]    r_idx;

    // Video timing decode; the preamble and guard band announce the next line.
    assign w_in_range    = (column < 16'(HTOTAL)) && (row < 16'(VTOTAL));
    assign w_next_row    = (row == 16'(VTOTAL - 1)) ? 16'd0 : row + 16'd1;
    assign w_next_active = (w_next_row < 16'(VACTIVE));
    assign w_video       = (column < 16'(HACTIVE)) && (row < 16'(VACTIVE));
    assign w_vid_pre     = w_next_active && (column >= 16'(HTOTAL - 10)) && (column <= 16'(HTOTAL - 3));
    assign w_vid_gb      = w_next_active && (column >= 16'(HTOTAL - 2)) && (column <= 16'(HTOTAL - 1));
    assign w_override    = !w_in_range || w_video || w_vid_pre || w_vid_gb;

    hdmi_island_fsm #(
        .ISLAND_START (ISLAND_START)
    ) u_island_fsm (
        .pix_clk     (pix_clk),
        .reset       (reset),
        .column      (column),
        .pkt_valid   (pkt_valid),
        .override    (w_override),
        .pkt_ready   (pkt_ready),
        .pkt_done    (pkt_done),
        .phase_state (w_isl_state),
        .pkt_word    (w_isl_word)
    );

    // Priority mux: out-of-frame, then video periods, then the island phase.
    always_comb begin
        w_period = CTRL;
        w_ctl    = 4'b0000;
        w_idx    = 5'd0;
        if (!w_in_range) begin
            w_period = CTRL;
        end else if (w_video) begin
            w_period = VIDEO;
        end else if (w_vid_pre) begin
            w_period = VID_PRE;
            w_ctl    = CTL_VIDEO_PRE;
        end else if (w_vid_gb) begin
            w_period = VID_GB;
        end else begin
            case (w_isl_state)
                ISL_PRE: begin
                    w_period = DI_PRE;
                    w_ctl    = CTL_ISLAND_PRE;
                end
                ISL_GB_LEAD:  w_period = DI_GB_LEAD;
                ISL_DATA: begin
                    w_period = DI_DATA;
                    w_idx    = w_isl_word;
                end
                ISL_GB_TRAIL: w_period = DI_GB_TRAIL;
                default:      w_period = CTRL;
            endcase
        end
    end

    // One-cycle output register; the HDMI top delays pixel data to match.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            r_period <= CTRL;
            r_ctl    <= 4'b0000;
            r_idx    <= 5'd0;
        end else begin
            r_period <= w_period;
            r_ctl    <= w_ctl;
            r_idx    <= w_idx;
        end
    end

    assign period    = r_period;
    assign ctl       = r_ctl;
    assign pkt_index = r_idx;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler at the default 800x525 timing.
module tb_hdmi_period_scheduler;
    import hdmi_pkg::*;

    logic        pix_clk = 1'b0;
    logic        reset;
    logic [15:0] column;
    logic [15:0] row;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_done;
    period_t     period;
    logic [3:0]  ctl;
    logic [4:0]  pkt_index;

    hdmi_period_scheduler dut (
        .pix_clk   (pix_clk),
        .reset     (reset),
        .column    (column),
        .row       (row),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_done  (pkt_done),
        .period    (period),
        .ctl       (ctl),
        .pkt_index (pkt_index)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        logic [2:0] per;
        logic [3:0] ctl;
        logic [4:0] idx;
        logic       done;
        int         r;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_acc = 1'b0;
    int   m_acc_row = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one row/column, predict the registered output, compare it after the edge.
    task automatic drive(input int r, input int c, input bit v, input bit rst);
        exp_t e;
        bit   rdy_e;
        int   nr;
        int   off;
        row       = 16'(r);
        column    = 16'(c);
        pkt_valid = v;
        reset     = rst;
        #1;
        rdy_e = !rst && !m_acc && (c == 655);
        check_val($sformatf("pkt_ready r%0d c%0d", r, c), {31'b0, pkt_ready}, {31'b0, rdy_e});
        if (rdy_e && v) begin
            m_acc     = 1'b1;
            m_acc_row = r;
        end
        e.per  = CTRL;
        e.ctl  = 4'b0000;
        e.idx  = 5'd0;
        e.done = 1'b0;
        e.r    = r;
        e.c    = c;
        nr     = (r == 524) ? 0 : r + 1;
        if (rst) begin
            m_acc = 1'b0;
        end else if (c >= 800 || r >= 525) begin
            e.per = CTRL;
        end else if (c < 640 && r < 480) begin
            e.per = VIDEO;
        end else if (nr < 480 && c >= 790 && c <= 797) begin
            e.per = VID_PRE;
            e.ctl = 4'b0001;
        end else if (nr < 480 && c >= 798) begin
            e.per = VID_GB;
        end else if (m_acc && r == m_acc_row) begin
            off = c - 656;
            if (off >= 0 && off <= 7) begin
                e.per = DI_PRE;
                e.ctl = 4'b0101;
            end else if (off >= 8 && off <= 9) begin
                e.per = DI_GB_LEAD;
            end else if (off >= 10 && off <= 41) begin
                e.per = DI_DATA;
                e.idx = 5'(off - 10);
            end else if (off >= 42 && off <= 43) begin
                e.per  = DI_GB_TRAIL;
                e.done = (off == 43);
            end
            if (off >= 43) m_acc = 1'b0;
        end
        sb.push_back(e);
        @(posedge pix_clk);
        #1;
        e = sb.pop_front();
        check_val($sformatf("period r%0d c%0d", e.r, e.c), {29'b0, period}, {29'b0, e.per});
        check_val($sformatf("ctl r%0d c%0d", e.r, e.c), {28'b0, ctl}, {28'b0, e.ctl});
        check_val($sformatf("pkt_index r%0d c%0d", e.r, e.c), {27'b0, pkt_index}, {27'b0, e.idx});
        check_val($sformatf("pkt_done r%0d c%0d", e.r, e.c), {31'b0, pkt_done}, {31'b0, e.done});
        $display("row %0d col %0d rst %0d valid %0d -> period %0d ctl %b idx %0d done %0d ready %0d",
                 e.r, e.c, rst, v, period, ctl, pkt_index, pkt_done, rdy_e);
    endtask

    initial begin
        reset     = 1'b1;
        row       = 16'd0;
        column    = 16'd655;
        pkt_valid = 1'b1;

        // Reset held three cycles at the accept column with a request pending.
        for (int i = 0; i < 3; i++) drive(0, 655, 1'b1, 1'b1);

        // Blanking sweep into an active line.
        for (int c = 788; c <= 799; c++) drive(5, c, 1'b0, 1'b0);
        drive(6, 0, 1'b0, 1'b0);

        // No preamble before the first blanking line; preamble before line 0.
        drive(479, 790, 1'b0, 1'b0);
        drive(524, 790, 1'b0, 1'b0);

        // Full island on row 10.
        for (int c = 650; c <= 702; c++) drive(10, c, 1'b1, 1'b0);

        // Reset in the middle of a packet (output index 10), then re-request.
        for (int c = 650; c <= 676; c++) drive(30, c, 1'b1, 1'b0);
        drive(30, 677, 1'b1, 1'b1);
        for (int c = 678; c <= 705; c++) drive(30, c, 1'b1, 1'b0);
        for (int c = 650; c <= 702; c++) drive(31, c, 1'b1, 1'b0);

        // Request arriving after the decision column waits for the next line.
        for (int c = 650; c <= 702; c++) drive(10, c, (c >= 660), 1'b0);
        for (int c = 650; c <= 702; c++) drive(11, c, 1'b1, 1'b0);
        drive(11, 703, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
